// File: rtl/hartslag_meter.sv
// -----------------------------------------------------------------------------
// hartslag_meter
//   Heartbeat-interval meter. Counts clocks between accepted rising edges of an
//   asynchronous beat pulse, rejects edges inside a refractory window, detects
//   signal loss by timeout, and publishes a scaled, saturated interval on an
//   update strobe.
//
//   Optional feature macro: HARTSLAG_AVG_EN
//     defined   -> moving average over 2^AVG_LOG2 intervals (one extra clock
//                  of latency, ring prefilled by the first interval after IDLE)
//     undefined -> freq follows the latest interval only
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-high reset
//   ingang        in   raw beat pulse, asynchronous to clk
//   update_en     in   one-cycle publish strobe
//   uitvoer       out  published scaled interval [OUT_W-1:0]
//   geldig        out  published value is valid
//   beat_strobe   out  one-cycle pulse per accepted (or arming) beat
//   afgewezen     out  one-cycle pulse per rejected edge
//   timeout_flag  out  one-cycle pulse on signal loss
// -----------------------------------------------------------------------------
module hartslag_meter #(
    parameter int CNT_W    = 25,
    parameter int OUT_W    = 6,
    parameter int SHIFT    = 18,
    parameter int MIN_INT  = 4096,
    parameter int TIMEOUT  = 1 << 24,
    parameter int AVG_LOG2 = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ingang,
    input  logic             update_en,
    output logic [OUT_W-1:0] uitvoer,
    output logic             geldig,
    output logic             beat_strobe,
    output logic             afgewezen,
    output logic             timeout_flag
);

    typedef enum logic [1:0] {IDLE, ARMED, TRACK} state_t;

    localparam logic [CNT_W-1:0] MIN_C   = CNT_W'(MIN_INT);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Elaboration-time guard against inconsistent parameter sets.
    if (SHIFT + OUT_W > CNT_W || TIMEOUT <= MIN_INT ||
        TIMEOUT > (2 ** CNT_W) - 1 || AVG_LOG2 < 1) begin : g_bad_params
        $error("hartslag_meter: inconsistent parameters");
    end

    logic             sync1, sync2, sync3;
    logic             edge_det;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] intv;
    logic             intv_vld;
    logic [OUT_W-1:0] freq;
    logic             fresh;
    logic             arm, accept, reject, timeout_hit;
    logic             new_vld;
    logic [CNT_W-1:0] new_val;

    // Two synchroniser stages plus one history stage for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep this a true 3-stage shift
            // chain; blocking ones would collapse it into a single flop.
            sync1 <= ingang;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign edge_det = sync2 & ~sync3;

    // Event decode. An edge always takes priority over the timeout, so an edge
    // landing exactly on cnt == TIMEOUT-1 is accepted rather than lost.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        arm         = 1'b0;
        accept      = 1'b0;
        reject      = 1'b0;
        timeout_hit = 1'b0;
        if (state == IDLE) begin
            arm = edge_det;
        end else if (edge_det) begin
            accept = (cnt >= MIN_C);
            reject = (cnt <  MIN_C);
        end else begin
            timeout_hit = (cnt == TO_LAST);
        end
    end

    // Beat FSM with interval counter and registered strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            intv         <= '0;
            intv_vld     <= 1'b0;
            beat_strobe  <= 1'b0;
            afgewezen    <= 1'b0;
            timeout_flag <= 1'b0;
        end else begin
            beat_strobe  <= arm | accept;
            afgewezen    <= reject;
            timeout_flag <= timeout_hit;
            intv_vld     <= accept;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (arm) state <= ARMED;
                end
                default: begin
                    if (accept) begin
                        intv  <= cnt;
                        cnt   <= '0;
                        state <= TRACK;
                    end else if (timeout_hit) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    // Map an interval onto the output window, saturating on overflow.
    function automatic logic [OUT_W-1:0] scale(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] hi;
        hi = v >> (SHIFT + OUT_W);
        if (hi != '0) return '1;
        return v[SHIFT +: OUT_W];
    endfunction

`ifdef HARTSLAG_AVG_EN
    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SUM_W = CNT_W + AVG_LOG2;

    logic [CNT_W-1:0]    ring [DEPTH];
    logic [AVG_LOG2-1:0] ptr;
    logic [SUM_W-1:0]    sum;
    logic                hist_empty;
    logic                avg_vld;

    // Running sum over the ring; ptr always addresses the oldest entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the ring is explicitly cleared because its contents feed
            // the running sum; an unreset history would corrupt the average.
            for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
            ptr        <= '0;
            sum        <= '0;
            hist_empty <= 1'b1;
            avg_vld    <= 1'b0;
        end else begin
            avg_vld <= intv_vld & ~timeout_hit;
            if (timeout_hit) begin
                for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
                ptr        <= '0;
                sum        <= '0;
                hist_empty <= 1'b1;
            end else if (intv_vld) begin
                if (hist_empty) begin
                    // First interval after IDLE fills every slot: no warm-up.
                    for (int i = 0; i < DEPTH; i++) ring[i] <= intv;
                    sum        <= SUM_W'(intv) << AVG_LOG2;
                    ptr        <= '0;
                    hist_empty <= 1'b0;
                end else begin
                    ring[ptr] <= intv;
                    sum       <= sum - SUM_W'(ring[ptr]) + SUM_W'(intv);
                    ptr       <= ptr + AVG_LOG2'(1);
                end
            end
        end
    end

    assign new_vld = avg_vld;
    assign new_val = sum[SUM_W-1:AVG_LOG2];
`else
    assign new_vld = intv_vld;
    assign new_val = intv;
`endif

    // freq register and publish stage. Publishing samples the pre-update
    // freq when update_en coincides with a freq load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            freq    <= '0;
            fresh   <= 1'b0;
            uitvoer <= '0;
            geldig  <= 1'b0;
        end else begin
            if (update_en) begin
                uitvoer <= freq;
                geldig  <= (state == TRACK) && fresh;
            end
            if (timeout_hit) begin
                freq  <= '0;
                fresh <= 1'b0;
            end else if (new_vld) begin
                freq  <= scale(new_val);
                fresh <= 1'b1;
            end
        end
    end

endmodule
